// File: rtl/vend_credit_fsm.sv
// Coin-credit controller for the vending machine: accumulates coins, sells one
// product, refunds change unit by unit and drives the dispense lamp latch.
module vend_credit_fsm #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 30,
  parameter int MAX_CREDIT  = 95,
  parameter int CHANGE_UNIT = 5,
  parameter int DISP_HOLD   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                coin_25,
  input  logic                select,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                lamp_set,
  output logic                lamp_reset,
  output logic                change_pulse,
  output logic                busy
);

  // state    | meaning
  // CLEAR    | post-reset, forces the lamp latch low
  // IDLE     | no credit, accepting coins
  // CREDIT   | credit > 0, accepting coins, select and cancel
  // DISPENSE | product out, held DISP_HOLD cycles
  // CHANGE   | refunding one CHANGE_UNIT every other cycle
  // DONE     | lamp_reset pulse, back to IDLE
  typedef enum logic [2:0] {
    CLEAR, IDLE, CREDIT, DISPENSE, CHANGE, DONE
  } state_t;

  localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                phase_q, phase_d;
  logic                coin_reject_q, coin_reject_d;
  logic                lamp_set_q, lamp_set_d;
  logic                lamp_reset_q, lamp_reset_d;
  logic                change_pulse_q, change_pulse_d;
  logic                busy_q, busy_d;

  logic                coin_any;
  logic                coin_one;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;

  always_comb begin
    coin_val = '0;
    coin_one = 1'b0;
    case ({coin_25, coin_10, coin_5})
      3'b001:  begin coin_val = CREDIT_W'(5);  coin_one = 1'b1; end
      3'b010:  begin coin_val = CREDIT_W'(10); coin_one = 1'b1; end
      3'b100:  begin coin_val = CREDIT_W'(25); coin_one = 1'b1; end
      default: begin coin_val = '0;            coin_one = 1'b0; end
    endcase
    coin_any = coin_5 | coin_10 | coin_25;
    coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    hold_d         = hold_q;
    phase_d        = phase_q;
    coin_reject_d  = 1'b0;
    lamp_set_d     = 1'b0;
    lamp_reset_d   = 1'b0;
    change_pulse_d = 1'b0;

    case (state_q)
      CLEAR: begin
        lamp_reset_d  = 1'b1;
        state_d       = IDLE;
        coin_reject_d = coin_any;
      end
      IDLE, CREDIT: begin
        if (state_q == CREDIT && cancel) begin
          state_d       = CHANGE;
          phase_d       = 1'b0;
          coin_reject_d = coin_any;
        end else if (state_q == CREDIT && select && credit_q >= CREDIT_W'(PRICE)) begin
          state_d       = DISPENSE;
          lamp_set_d    = 1'b1;
          credit_d      = credit_q - CREDIT_W'(PRICE);
          hold_d        = HOLD_W'(DISP_HOLD - 1);
          coin_reject_d = coin_any;
        end else if (coin_any) begin
          if (coin_one && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_any;
        if (hold_q == '0) begin
          state_d = CHANGE;
          phase_d = 1'b0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_any;
        // phase 1 is the mandatory low cycle between change pulses
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (credit_q >= CREDIT_W'(CHANGE_UNIT)) begin
          change_pulse_d = 1'b1;
          credit_d       = credit_q - CREDIT_W'(CHANGE_UNIT);
          phase_d        = 1'b1;
        end else begin
          credit_d     = '0;
          lamp_reset_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        coin_reject_d = coin_any;
        state_d       = IDLE;
      end
      default: begin
        state_d  = CLEAR;
        credit_d = '0;
      end
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == CHANGE) ||
             (state_d == DONE)     || (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= CLEAR;
      credit_q       <= '0;
      hold_q         <= '0;
      phase_q        <= 1'b0;
      coin_reject_q  <= 1'b0;
      lamp_set_q     <= 1'b0;
      lamp_reset_q   <= 1'b0;
      change_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      hold_q         <= hold_d;
      phase_q        <= phase_d;
      coin_reject_q  <= coin_reject_d;
      lamp_set_q     <= lamp_set_d;
      lamp_reset_q   <= lamp_reset_d;
      change_pulse_q <= change_pulse_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign lamp_set     = lamp_set_q;
  assign lamp_reset   = lamp_reset_q;
  assign change_pulse = change_pulse_q;
  assign busy         = busy_q;

endmodule
